// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: default datapath width,
// Y86 ALU function codes and the request payload bundle.
// No logic; imported by the interface, the ALU core and the arbiter top.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 64;

  localparam logic [1:0] IFUN_ADD = 2'd0;
  localparam logic [1:0] IFUN_SUB = 2'd1;
  localparam logic [1:0] IFUN_AND = 2'd2;
  localparam logic [1:0] IFUN_XOR = 2'd3;

  // One ALU request as seen after the requester mux.
  typedef struct packed {
    logic [1:0]               ifun;
    logic [WIDTH_DEFAULT-1:0] a;
    logic [WIDTH_DEFAULT-1:0] b;
    logic                     set_cc;
  } alu_op_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// Bundle of the two requester channels, the response channel and the CC flags.
// master: the requesters/consumer side. slave: the arbiter.
// Ports: req{0,1}_{valid,ready,ifun,a,b,set_cc}, rsp_{valid,ready,id,result,overflow}, cc_{zf,sf,of}.
interface alu_share_arb_if
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_ifun;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_set_cc;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_ifun;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_set_cc;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_overflow;

  logic             cc_zf;
  logic             cc_sf;
  logic             cc_of;

  modport master (
    output req0_valid, req0_ifun, req0_a, req0_b, req0_set_cc,
    input  req0_ready,
    output req1_valid, req1_ifun, req1_a, req1_b, req1_set_cc,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_overflow,
    output rsp_ready,
    input  cc_zf, cc_sf, cc_of
  );

  modport slave (
    input  req0_valid, req0_ifun, req0_a, req0_b, req0_set_cc,
    output req0_ready,
    input  req1_valid, req1_ifun, req1_a, req1_b, req1_set_cc,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_overflow,
    input  rsp_ready,
    output cc_zf, cc_sf, cc_of
  );

endinterface

// File: rtl/add64.sv
// Adder with carry-in and signed-overflow detect (x + y + cin).
// Purely combinational, no backpressure.
// Ports: x_i, y_i operands; cin_i carry in; sum_o result; ovf_o signed overflow.
module add64 #(
  parameter int W = 64
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  assign sum_o = x_i + y_i + {{(W-1){1'b0}}, cin_i};

  // Two same-signed addends producing a result of the other sign overflowed.
  assign ovf_o = (x_i[W-1] == y_i[W-1]) && (sum_o[W-1] != x_i[W-1]);

endmodule

// File: rtl/alu_core.sv
// Y86 ALU: ADD b+a, SUB b-a, AND b&a, XOR b^a, with signed overflow.
// Purely combinational, no backpressure.
// Ports: ifun_i function code; a_i, b_i operands; result_o; overflow_o.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [1:0]       ifun_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             overflow_o
);

  logic             is_sub;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;

  // SUB reuses the adder as b + ~a + 1. The adder's same-sign overflow test on
  // (~a, b) is exactly "a and b differ in sign and the result differs from b".
  assign is_sub = (ifun_i == IFUN_SUB);
  assign add_x  = is_sub ? ~a_i : a_i;

  add64 #(.W(WIDTH)) u_add (
    .x_i  (add_x),
    .y_i  (b_i),
    .cin_i(is_sub),
    .sum_o(add_sum),
    .ovf_o(add_ovf)
  );

  always_comb begin
    result_o   = add_sum;
    overflow_o = 1'b0;
    case (ifun_i)
      IFUN_ADD, IFUN_SUB: begin
        result_o   = add_sum;
        overflow_o = add_ovf;
      end
      IFUN_AND: result_o = b_i & a_i;
      IFUN_XOR: result_o = b_i ^ a_i;
      default:  result_o = add_sum;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between two requesters (round-robin) into a one-entry result buffer; owns ZF/SF/OF.
// Latency: result on rsp_* one cycle after the grant edge; CC flags likewise.
// Backpressure: grants only while the buffer is empty or being drained this cycle; full buffer holds.
// Ports: clk, rst_n (sync, active-low); bus (slave side of alu_share_arb_if).
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_share_arb_if.slave  bus
);

  logic             can_accept;
  logic             gnt0;
  logic             gnt1;
  logic             gnt_any;
  alu_op_t          op_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             of_q, of_d;
  // prio_q: requester that wins when both are valid (1 = requester 1).
  logic             prio_q, prio_d;

  // Grant is a pure function of the valids, the pointer and buffer space.
  // rst_n gates it so nothing is accepted while reset is held.
  always_comb begin
    can_accept = !rsp_valid_q || bus.rsp_ready;
    gnt0       = rst_n && can_accept && bus.req0_valid && (!bus.req1_valid || !prio_q);
    gnt1       = rst_n && can_accept && bus.req1_valid && (!bus.req0_valid ||  prio_q);
    gnt_any    = gnt0 || gnt1;
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  always_comb begin
    if (gnt1) begin
      op_sel.ifun   = bus.req1_ifun;
      op_sel.a      = bus.req1_a;
      op_sel.b      = bus.req1_b;
      op_sel.set_cc = bus.req1_set_cc;
    end else begin
      op_sel.ifun   = bus.req0_ifun;
      op_sel.a      = bus.req0_a;
      op_sel.b      = bus.req0_b;
      op_sel.set_cc = bus.req0_set_cc;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .ifun_i    (op_sel.ifun),
    .a_i       (op_sel.a),
    .b_i       (op_sel.b),
    .result_o  (alu_result),
    .overflow_o(alu_ovf)
  );

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    zf_d         = zf_q;
    sf_d         = sf_q;
    of_d         = of_q;
    prio_d       = prio_q;
    if (gnt_any) begin
      // A grant also covers the drain-and-refill case: no bubble.
      rsp_valid_d  = 1'b1;
      rsp_id_d     = gnt1;
      rsp_result_d = alu_result;
      rsp_ovf_d    = alu_ovf;
      prio_d       = gnt0;
      // CC follows the grant, not the consumer handshake.
      if (op_sel.set_cc) begin
        zf_d = (alu_result == '0);
        sf_d = alu_result[WIDTH-1];
        of_d = alu_ovf;
      end
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      zf_q         <= 1'b1;
      sf_q         <= 1'b0;
      of_q         <= 1'b0;
      prio_q       <= 1'b0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      zf_q         <= zf_d;
      sf_q         <= sf_d;
      of_q         <= of_d;
      prio_q       <= prio_d;
    end
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign bus.cc_zf        = zf_q;
  assign bus.cc_sf        = sf_q;
  assign bus.cc_of        = of_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: table of single-request vectors plus
// hand-written round-robin, backpressure and reset-mid-operation sequences.
module tb_alu_share_arb;
  import alu_pkg::*;

  logic clk;
  logic rst_n;

  alu_share_arb_if #(.WIDTH(64)) bus ();

  alu_share_arb #(.WIDTH(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [1:0]  ifun;
    logic [63:0] a;
    logic [63:0] b;
    logic        set_cc;
    logic [63:0] exp_res;
    logic        exp_ovf;
    logic        exp_zf;
    logic        exp_sf;
    logic        exp_of;
  } vec_t;

  vec_t vecs[9];
  int   total = 0;
  int   bad   = 0;
  logic last_g;
  logic w;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_rdy(input string nm, input logic e0, input logic e1);
    chk({nm, " req0_ready"}, {63'd0, bus.req0_ready}, {63'd0, e0});
    chk({nm, " req1_ready"}, {63'd0, bus.req1_ready}, {63'd0, e1});
  endtask

  task automatic chk_cc(input string nm, input logic zf, input logic sf, input logic of_);
    chk({nm, " zf"}, {63'd0, bus.cc_zf}, {63'd0, zf});
    chk({nm, " sf"}, {63'd0, bus.cc_sf}, {63'd0, sf});
    chk({nm, " of"}, {63'd0, bus.cc_of}, {63'd0, of_});
  endtask

  task automatic set_req(input logic sel, input logic vld, input logic [1:0] ifun,
                         input logic [63:0] a, input logic [63:0] b, input logic cc);
    if (sel) begin
      bus.req1_valid = vld; bus.req1_ifun = ifun;
      bus.req1_a = a; bus.req1_b = b; bus.req1_set_cc = cc;
    end else begin
      bus.req0_valid = vld; bus.req0_ifun = ifun;
      bus.req0_a = a; bus.req0_b = b; bus.req0_set_cc = cc;
    end
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic apply_vec(input vec_t v, input string nm);
    set_req(v.sel, 1'b1, v.ifun, v.a, v.b, v.set_cc);
    set_req(!v.sel, 1'b0, IFUN_ADD, 64'hDEAD, 64'hBEEF, 1'b1);
    bus.rsp_ready = 1'b1;
    #1;
    chk_rdy(nm, !v.sel, v.sel);
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk({nm, " rsp_valid"}, {63'd0, bus.rsp_valid}, 64'd1);
    chk({nm, " rsp_id"}, {63'd0, bus.rsp_id}, {63'd0, v.sel});
    chk({nm, " rsp_result"}, bus.rsp_result, v.exp_res);
    chk({nm, " rsp_overflow"}, {63'd0, bus.rsp_overflow}, {63'd0, v.exp_ovf});
    chk_cc(nm, v.exp_zf, v.exp_sf, v.exp_of);
    last_g = v.sel;
  endtask

  // Fixed round-robin / backpressure payloads: req0 ADD 1+100, req1 AND 0xFF&0x1234.
  function automatic logic [63:0] rr_res(input logic sel);
    return sel ? 64'h34 : 64'd101;
  endfunction

  initial begin
    //            sel  ifun      a                       b                       cc   result                  ovf  zf   sf   of
    vecs[0] = '{1'b0, IFUN_ADD, 64'd10,                 64'd19,                 1'b1, 64'd29,                 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, IFUN_SUB, 64'd5,                  64'd5,                  1'b1, 64'd0,                  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, IFUN_SUB, 64'd1,                  64'd0,                  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, IFUN_ADD, 64'd1,                  64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, IFUN_SUB, 64'd1,                  64'h8000_0000_0000_0000, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, IFUN_AND, 64'hF0,                 64'h3C,                 1'b1, 64'h30,                 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, IFUN_XOR, 64'hF0,                 64'h3C,                 1'b0, 64'hCC,                 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, IFUN_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b1, IFUN_SUB, 64'h8000_0000_0000_0000, 64'd0,                 1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset with both requesters valid: no ready may rise.
    rst_n = 1'b0;
    bus.rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, IFUN_ADD, 64'd3, 64'd4, 1'b1);
    set_req(1'b1, 1'b1, IFUN_ADD, 64'd5, 64'd6, 1'b1);
    last_g = 1'b1;
    @(negedge clk);
    chk_rdy("in reset", 1'b0, 1'b0);
    @(negedge clk);
    chk_rdy("in reset 2", 1'b0, 1'b0);
    chk("reset rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("reset rsp_id", {63'd0, bus.rsp_id}, 64'd0);
    chk("reset rsp_result", bus.rsp_result, 64'd0);
    chk("reset rsp_overflow", {63'd0, bus.rsp_overflow}, 64'd0);
    chk_cc("reset", 1'b1, 1'b0, 1'b0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Round robin: both valid, rsp_ready=1, grants alternate with no bubble.
    set_req(1'b0, 1'b1, IFUN_ADD, 64'd1, 64'd100, 1'b0);
    set_req(1'b1, 1'b1, IFUN_AND, 64'hFF, 64'h1234, 1'b0);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = !last_g;
      #1;
      chk_rdy($sformatf("rr%0d", i), !w, w);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rr%0d rsp_valid", i), {63'd0, bus.rsp_valid}, 64'd1);
      chk($sformatf("rr%0d rsp_id", i), {63'd0, bus.rsp_id}, {63'd0, w});
      chk($sformatf("rr%0d rsp_result", i), bus.rsp_result, rr_res(w));
      last_g = w;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("drain rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);

    // Backpressure: empty buffer, rsp_ready low, both valid -> exactly one grant.
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, IFUN_ADD, 64'd1, 64'd100, 1'b1);
    set_req(1'b1, 1'b1, IFUN_AND, 64'hFF, 64'h1234, 1'b1);
    w = !last_g;
    #1;
    chk_rdy("bp grant", !w, w);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_rdy($sformatf("bp stall%0d", i), 1'b0, 1'b0);
      chk($sformatf("bp stall%0d rsp_valid", i), {63'd0, bus.rsp_valid}, 64'd1);
      chk($sformatf("bp stall%0d rsp_id", i), {63'd0, bus.rsp_id}, {63'd0, w});
      chk($sformatf("bp stall%0d rsp_result", i), bus.rsp_result, rr_res(w));
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk_rdy("bp release", w, !w);
    @(posedge clk);
    @(negedge clk);
    chk("bp next rsp_id", {63'd0, bus.rsp_id}, {63'd0, !w});
    chk("bp next rsp_result", bus.rsp_result, rr_res(!w));
    chk_cc("bp next", 1'b0, 1'b0, 1'b0);
    last_g = !w;

    // Reset while a result is buffered and a request is valid.
    bus.rsp_ready = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_rdy("mid reset", 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk_rdy("mid reset after", 1'b0, 1'b0);
    chk("mid reset rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk_cc("mid reset", 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    bus.req0_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("post reset no stray rsp", {63'd0, bus.rsp_valid}, 64'd0);

    // After reset the pointer favours requester 0.
    set_req(1'b0, 1'b1, IFUN_AND, 64'hF0, 64'h3C, 1'b1);
    set_req(1'b1, 1'b1, IFUN_XOR, 64'hF0, 64'h3C, 1'b1);
    #1;
    chk_rdy("post reset first", 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    chk("post reset AND id", {63'd0, bus.rsp_id}, 64'd0);
    chk("post reset AND", bus.rsp_result, 64'h30);
    #1;
    chk_rdy("post reset second", 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    chk("post reset XOR id", {63'd0, bus.rsp_id}, 64'd1);
    chk("post reset XOR", bus.rsp_result, 64'hCC);
    chk_cc("post reset XOR", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
